// File: rtl/ws2812b_pkg.sv
// Shared WS2812B timing constants (20 MHz clock), pixel RAM geometry and receiver FSM states.
package ws2812b_pkg;

  localparam int unsigned T0HighCyc    = 8;
  localparam int unsigned T1HighCyc    = 16;
  localparam int unsigned BitPeriodCyc = 25;
  localparam int unsigned ResetCyc     = 1000;

  // Receive-side decode thresholds derived from the transmit timing.
  localparam int unsigned HighMinCyc = T0HighCyc / 2;
  localparam int unsigned BitThCyc   = (T0HighCyc + T1HighCyc) / 2;
  localparam int unsigned HighMaxCyc = BitPeriodCyc - 1;

  localparam int unsigned PixelW   = 24;
  localparam int unsigned RamDepth = 512;
  localparam int unsigned RamAw    = 10;

  typedef enum logic [1:0] {
    StSync,
    StWait,
    StHigh
  } rx_state_e;

endpackage

// File: rtl/ws2812b_pulse_meter.sv
// Synchronizes the serial line, detects edges and measures high/low run lengths.
module ws2812b_pulse_meter #(
  parameter int unsigned HighW = 5,
  parameter int unsigned LowW  = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic [HighW-1:0] high_width_o,
  output logic [LowW-1:0]  low_count_o
);

  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [HighW-1:0] hi_q, hi_d;
  logic [LowW-1:0]  lo_q, lo_d;

  always_comb begin
    sync_d = {sync_q[0], din_i};
    prev_d = sync_q[1];
    hi_d   = '0;
    lo_d   = '0;
    // Each counter restarts when the line leaves its level and saturates at all-ones.
    if (sync_q[1]) begin
      hi_d = (hi_q == '1) ? hi_q : hi_q + 1'b1;
    end else begin
      lo_d = (lo_q == '1) ? lo_q : lo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign rise_o       = sync_q[1] & ~prev_q;
  assign fall_o       = ~sync_q[1] & prev_q;
  assign high_width_o = hi_q;
  assign low_count_o  = lo_q;

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812B stream receiver: decodes NRZ bits into 24-bit pixels and writes them to the pixel RAM.
module ws2812b_receiver
  import ws2812b_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RamAw,
  parameter int unsigned PIXEL_MAX  = RamDepth - 1,
  parameter int unsigned HIGH_MIN   = HighMinCyc,
  parameter int unsigned BIT_TH     = BitThCyc,
  parameter int unsigned HIGH_MAX   = HighMaxCyc,
  parameter int unsigned RESET_CNT  = ResetCyc
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  DIN,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [PixelW-1:0]     RAM_WDATA,
  output logic                  RAM_WE,
  output logic                  FRAME_DONE,
  output logic [ADDR_WIDTH:0]   PIXEL_COUNT,
  output logic                  ERR
);

  localparam int unsigned HighW   = $clog2(HIGH_MAX + 1);
  localparam int unsigned LowW    = $clog2(RESET_CNT + 1) + 1;
  localparam int unsigned BitIdxW = $clog2(PixelW);

  localparam logic [HighW-1:0]      HighMinL  = HighW'(HIGH_MIN);
  localparam logic [HighW-1:0]      BitThL    = HighW'(BIT_TH);
  localparam logic [HighW-1:0]      HighMaxL  = HighW'(HIGH_MAX);
  localparam logic [LowW-1:0]       ResetCntL = LowW'(RESET_CNT);
  localparam logic [ADDR_WIDTH-1:0] AddrMaxL  = ADDR_WIDTH'(PIXEL_MAX);
  localparam logic [ADDR_WIDTH:0]   PixMaxL   = (ADDR_WIDTH + 1)'(PIXEL_MAX);
  localparam logic [ADDR_WIDTH:0]   PixSatL   = (ADDR_WIDTH + 1)'(1 << ADDR_WIDTH);
  localparam logic [BitIdxW-1:0]    BitLastL  = BitIdxW'(PixelW - 1);

  logic             rise, fall;
  logic [HighW-1:0] high_width;
  logic [LowW-1:0]  low_count;

  ws2812b_pulse_meter #(
    .HighW (HighW),
    .LowW  (LowW)
  ) u_pulse_meter (
    .clk_i        (CLK),
    .rst_ni       (RESET),
    .din_i        (DIN),
    .rise_o       (rise),
    .fall_o       (fall),
    .high_width_o (high_width),
    .low_count_o  (low_count)
  );

  rx_state_e               state_q, state_d;
  // Holds the first 23 bits; the 24th is merged directly into the write word.
  logic [PixelW-2:0]       sr_q, sr_d;
  logic [BitIdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     pix_cnt_q, pix_cnt_d;
  logic                    pix_done_q, pix_done_d;
  logic                    we_q, we_d;
  logic [PixelW-1:0]       wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH:0]     pixel_count_q, pixel_count_d;
  logic                    err_q, err_d;

  logic reset_code, high_over, bit_val;

  assign reset_code = (low_count == ResetCntL);
  assign high_over  = (high_width >= HighMaxL);
  assign bit_val    = (high_width >= BitThL);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync:  if (reset_code) state_d = StWait;
      StWait:  if (rise) state_d = StHigh;
      StHigh: begin
        if (high_over) begin
          state_d = StSync;
        end else if (fall) begin
          state_d = StWait;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_comb begin
    sr_d          = sr_q;
    bit_idx_d     = bit_idx_q;
    addr_d        = addr_q;
    pix_cnt_d     = pix_cnt_q;
    pix_done_d    = 1'b0;
    we_d          = 1'b0;
    wdata_d       = wdata_q;
    done_d        = 1'b0;
    pixel_count_d = pixel_count_q;
    err_d         = err_q;

    // Advance the pixel index the cycle after a pixel completes, written or not.
    if (pix_done_q) begin
      if (addr_q != AddrMaxL) addr_d = addr_q + 1'b1;
      if (pix_cnt_q != PixSatL) pix_cnt_d = pix_cnt_q + 1'b1;
    end

    unique case (state_q)
      StWait: begin
        if (reset_code) begin
          done_d        = 1'b1;
          pixel_count_d = pix_cnt_q;
          addr_d        = '0;
          bit_idx_d     = '0;
          pix_cnt_d     = '0;
          sr_d          = '0;
          if (bit_idx_q != '0) err_d = 1'b1;
        end else if (rise && pix_cnt_q == '0) begin
          err_d = 1'b0;
        end
      end
      StHigh: begin
        if (high_over) begin
          err_d     = 1'b1;
          addr_d    = '0;
          bit_idx_d = '0;
          pix_cnt_d = '0;
          sr_d      = '0;
        end else if (fall && high_width >= HighMinL) begin
          sr_d = {sr_q[PixelW-3:0], bit_val};
          if (bit_idx_q == BitLastL) begin
            bit_idx_d  = '0;
            pix_done_d = 1'b1;
            if (pix_cnt_q > PixMaxL) begin
              err_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              wdata_d = {sr_q, bit_val};
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sr_q          <= '0;
      bit_idx_q     <= '0;
      addr_q        <= '0;
      pix_cnt_q     <= '0;
      pix_done_q    <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      done_q        <= 1'b0;
      pixel_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      bit_idx_q     <= bit_idx_d;
      addr_q        <= addr_d;
      pix_cnt_q     <= pix_cnt_d;
      pix_done_q    <= pix_done_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      done_q        <= done_d;
      pixel_count_q <= pixel_count_d;
      err_q         <= err_d;
    end
  end

  assign RAM_ADDR    = addr_q;
  assign RAM_WDATA   = wdata_q;
  assign RAM_WE      = we_q;
  assign FRAME_DONE  = done_q;
  assign PIXEL_COUNT = pixel_count_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Directed bench for ws2812b_receiver: frames, glitches, framing errors, overflow and reset.
module tb_ws2812b_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [9:0]  ram_addr;
  logic [23:0] ram_wdata;
  logic        ram_we;
  logic        frame_done;
  logic [10:0] pixel_count;
  logic        err;

  ws2812b_receiver dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .DIN         (din),
    .RAM_ADDR    (ram_addr),
    .RAM_WDATA   (ram_wdata),
    .RAM_WE      (ram_we),
    .FRAME_DONE  (frame_done),
    .PIXEL_COUNT (pixel_count),
    .ERR         (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  int          done_cnt = 0;
  int          last_pc = 0;
  logic        last_err = 1'b0;
  logic [9:0]  wr_addr [0:1023];
  logic [23:0] wr_data [0:1023];

  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr[wr_cnt[9:0]] <= ram_addr;
      wr_data[wr_cnt[9:0]] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      last_pc  <= 32'(pixel_count);
      last_err <= err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(16, 9);
    else   pulse(8, 17);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic fast_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) pulse(w[i] ? 12 : 4, 2);
  endtask

  task automatic idle();
    din = 1'b0;
    repeat (1020) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_addr"},  32'(ram_addr), 0);
    check({tag, "_wdata"}, 32'(ram_wdata), 0);
    check({tag, "_we"},    32'(ram_we), 0);
    check({tag, "_done"},  32'(frame_done), 0);
    check({tag, "_pc"},    32'(pixel_count), 0);
    check({tag, "_err"},   32'(err), 0);
  endtask

  int wb, db, bad;
  logic [23:0] w3;

  initial begin
    repeat (5) @(negedge clk);
    check_zero_outputs("rst");
    rst_n = 1'b1;
    idle();
    check("sync_no_done", done_cnt, 0);

    // Three exact-timing pixels.
    wb = wr_cnt; db = done_cnt;
    send_pixel(24'hFF0000);
    send_pixel(24'h00FF00);
    send_pixel(24'h0000A5);
    idle();
    check("t1_nwr", wr_cnt - wb, 3);
    check("t1_a0", 32'(wr_addr[10'(wb)]), 0);
    check("t1_d0", 32'(wr_data[10'(wb)]), 32'h00FF0000);
    check("t1_a1", 32'(wr_addr[10'(wb + 1)]), 1);
    check("t1_d1", 32'(wr_data[10'(wb + 1)]), 32'h0000FF00);
    check("t1_a2", 32'(wr_addr[10'(wb + 2)]), 2);
    check("t1_d2", 32'(wr_data[10'(wb + 2)]), 32'h000000A5);
    check("t1_ndone", done_cnt - db, 1);
    check("t1_pc", last_pc, 3);
    check("t1_err", 32'(last_err), 0);

    // 34-bit frame: one pixel plus a 10-bit partial.
    wb = wr_cnt; db = done_cnt;
    send_pixel(24'h123456);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    idle();
    check("t2_nwr", wr_cnt - wb, 1);
    check("t2_d0", 32'(wr_data[10'(wb)]), 32'h00123456);
    check("t2_pc", last_pc, 1);
    check("t2_err", 32'(last_err), 1);
    check("t2_err_sticky", 32'(err), 1);
    wb = wr_cnt;
    send_bit(1'b1);
    check("t2_err_clr", 32'(err), 0);
    for (int i = 22; i >= 0; i--) send_bit(w3_bit(24'hABCDEF, i));
    idle();
    check("t2b_d0", 32'(wr_data[10'(wb)]), 32'h00ABCDEF);
    check("t2b_a0", 32'(wr_addr[10'(wb)]), 0);
    check("t2b_err", 32'(last_err), 0);

    // Glitches and boundary widths 11 / 12 / 23.
    wb = wr_cnt;
    w3 = 24'h75A5A5;
    pulse(11, 10); pulse(2, 10);
    pulse(12, 10); pulse(2, 10);
    pulse(23, 10); pulse(2, 10);
    for (int i = 20; i >= 0; i--) send_bit(w3[i]);
    idle();
    check("t3_nwr", wr_cnt - wb, 1);
    check("t3_d0", 32'(wr_data[10'(wb)]), 32'h0075A5A5);
    check("t3_pc", last_pc, 1);
    check("t3_err", 32'(last_err), 0);

    // Framing error: high held 24 cycles.
    wb = wr_cnt; db = done_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    pulse(24, 10);
    check("t4_err", 32'(err), 1);
    send_pixel(24'hFFFFFF);
    idle();
    check("t4_nwr", wr_cnt - wb, 0);
    check("t4_ndone", done_cnt - db, 0);
    check("t4_err_hold", 32'(err), 1);
    send_pixel(24'h5A5A5A);
    idle();
    check("t4_nwr2", wr_cnt - wb, 1);
    check("t4_a0", 32'(wr_addr[10'(wb)]), 0);
    check("t4_d0", 32'(wr_data[10'(wb)]), 32'h005A5A5A);
    check("t4_pc", last_pc, 1);
    check("t4_err2", 32'(last_err), 0);

    // 513 pixels: the last one overflows the RAM.
    wb = wr_cnt;
    for (int p = 0; p < 513; p++) begin
      for (int i = 0; i < 24; i++) pulse(4, 1);
    end
    idle();
    check("t5_nwr", wr_cnt - wb, 512);
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (32'(wr_addr[10'(wb + k)]) != k) bad++;
    end
    check("t5_addr_seq", bad, 0);
    check("t5_last_addr", 32'(wr_addr[10'(wb + 511)]), 511);
    check("t5_pc", last_pc, 513);
    check("t5_err", 32'(last_err), 1);

    // Reset during bit 12 of pixel 5.
    wb = wr_cnt; db = done_cnt;
    for (int p = 0; p < 5; p++) fast_pixel(24'h800001);
    for (int i = 0; i < 11; i++) pulse(12, 2);
    din = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_nwr", wr_cnt - wb, 5);
    check("t6_addr_pre", 32'(ram_addr), 5);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_rst");
    @(negedge clk);
    din = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wb = wr_cnt;
    fast_pixel(24'hFFFFFF);
    fast_pixel(24'h0F0F0F);
    repeat (10) @(negedge clk);
    check("t6_nwr_post", wr_cnt - wb, 0);
    check("t6_ndone", done_cnt - db, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic w3_bit(input logic [23:0] w, input int i);
    return w[i];
  endfunction

endmodule
